rsa_cmd_responder: RTL and testbench

- FPGA-side responder for the ARM-to-FPGA command/data protocol: decodes 32-bit commands and accepts 1024-bit operand words into the modulus, R²/A-B and exponent registers.
- Launches the exponentiation or Montgomery core, and returns the result word with a valid/ready handshake.
- Signals completion of every command with a level `done` held until the ARM acknowledges it.
- Sits inside the RSA wrapper, between the ARM bus ports and the compute cores.

---
 rtl/rsa_cmd_responder.sv | 148 ++++++++++++++
 tb/tb_rsa_cmd_responder.sv | 382 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rsa_cmd_responder.sv
// ARM-to-FPGA command responder: decodes commands, loads operand registers,
// launches the exp/Montgomery cores and returns results. Optional macro: RSA_RESP_ERR_EN.
module rsa_cmd_responder #(
    parameter int DATA_W = 1024,
    parameter int CMD_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [CMD_W-1:0]  arm_to_fpga_cmd,
    input  logic              arm_to_fpga_cmd_valid,
    output logic              fpga_to_arm_done,
    input  logic              fpga_to_arm_done_read,
    input  logic              arm_to_fpga_data_valid,
    output logic              arm_to_fpga_data_ready,
    input  logic [DATA_W-1:0] arm_to_fpga_data,
    output logic              fpga_to_arm_data_valid,
    input  logic              fpga_to_arm_data_ready,
    output logic [DATA_W-1:0] fpga_to_arm_data,
    output logic [DATA_W-1:0] mod_q,
    output logic [DATA_W-1:0] rsq_q,
    output logic [DATA_W-1:0] exp_q,
    output logic              exp_start,
    output logic              mont_start,
    input  logic              core_done,
    input  logic [DATA_W-1:0] core_result,
    output logic [3:0]        leds
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RX   = 3'd1,
        S_RUN  = 3'd2,
        S_TX   = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [2:0]        r_op;
    logic              r_exp_start;
    logic              r_mont_start;
    logic [DATA_W-1:0] r_mod;
    logic [DATA_W-1:0] r_rsq;
    logic [DATA_W-1:0] r_exp;
    logic [DATA_W-1:0] r_result;
    logic [2:0]        w_op;
    logic              w_cmd_accept;
    logic              w_err;
    logic              w_unused_cmd;

    // Only the low three command bits carry an opcode.
    assign w_op         = arm_to_fpga_cmd[2:0];
    assign w_unused_cmd = ^arm_to_fpga_cmd[CMD_W-1:3];
    assign w_cmd_accept = arm_to_fpga_cmd_valid && (r_state == S_IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (arm_to_fpga_cmd_valid) begin
                    case (w_op)
                        3'd0, 3'd1:       w_state_nxt = S_RUN;
                        3'd2, 3'd3, 3'd4: w_state_nxt = S_RX;
                        3'd5:             w_state_nxt = S_TX;
                        default:          w_state_nxt = S_DONE;
                    endcase
                end
            end
            S_RX:    if (arm_to_fpga_data_valid) w_state_nxt = S_DONE;
            S_RUN:   if (core_done)              w_state_nxt = S_DONE;
            S_TX:    if (fpga_to_arm_data_ready) w_state_nxt = S_DONE;
            S_DONE:  if (fpga_to_arm_done_read)  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Handshake outputs are Moore decodes of the state register.
    always_comb begin
        fpga_to_arm_done       = (r_state == S_DONE);
        arm_to_fpga_data_ready = (r_state == S_RX);
        fpga_to_arm_data_valid = (r_state == S_TX);
        leds                   = {w_err, r_state};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_op         <= 3'd0;
            r_exp_start  <= 1'b0;
            r_mont_start <= 1'b0;
            r_mod        <= '0;
            r_rsq        <= '0;
            r_exp        <= '0;
            r_result     <= '0;
        end else begin
            r_exp_start  <= w_cmd_accept && (w_op == 3'd0);
            r_mont_start <= w_cmd_accept && (w_op == 3'd1);
            if (w_cmd_accept) begin
                r_op <= w_op;
            end
            if ((r_state == S_RX) && arm_to_fpga_data_valid) begin
                case (r_op)
                    3'd2:    r_mod <= arm_to_fpga_data;
                    3'd3:    r_rsq <= arm_to_fpga_data;
                    3'd4:    r_exp <= arm_to_fpga_data;
                    default: ;
                endcase
            end
            if ((r_state == S_RUN) && core_done) begin
                r_result <= core_result;
            end
        end
    end

`ifdef RSA_RESP_ERR_EN
    logic r_err;

    // Sticky protocol-abuse flag; only reset clears it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_err <= 1'b0;
        end else if ((arm_to_fpga_cmd_valid && (r_state != S_IDLE)) ||
                     (w_cmd_accept && (w_op[2:1] == 2'b11)) ||
                     (arm_to_fpga_data_valid && (r_state == S_IDLE))) begin
            r_err <= 1'b1;
        end
    end

    assign w_err = r_err;
`else
    assign w_err = 1'b0;
`endif

    assign exp_start        = r_exp_start;
    assign mont_start       = r_mont_start;
    assign mod_q            = r_mod;
    assign rsq_q            = r_rsq;
    assign exp_q            = r_exp;
    assign fpga_to_arm_data = r_result;

endmodule

// File: tb/tb_rsa_cmd_responder.sv
// Scoreboard bench for rsa_cmd_responder: result words are queued when the core
// model produces them and popped when the responder returns them to the ARM side.
module tb_rsa_cmd_responder;

    localparam int DATA_W = 1024;
    localparam int CMD_W  = 32;

    logic              clk;
    logic              reset;
    logic [CMD_W-1:0]  arm_to_fpga_cmd;
    logic              arm_to_fpga_cmd_valid;
    logic              fpga_to_arm_done;
    logic              fpga_to_arm_done_read;
    logic              arm_to_fpga_data_valid;
    logic              arm_to_fpga_data_ready;
    logic [DATA_W-1:0] arm_to_fpga_data;
    logic              fpga_to_arm_data_valid;
    logic              fpga_to_arm_data_ready;
    logic [DATA_W-1:0] fpga_to_arm_data;
    logic [DATA_W-1:0] mod_q;
    logic [DATA_W-1:0] rsq_q;
    logic [DATA_W-1:0] exp_q;
    logic              exp_start;
    logic              mont_start;
    logic              core_done;
    logic [DATA_W-1:0] core_result;
    logic [3:0]        leds;

    rsa_cmd_responder #(.DATA_W(DATA_W), .CMD_W(CMD_W)) dut (
        .clk                    (clk),
        .reset                  (reset),
        .arm_to_fpga_cmd        (arm_to_fpga_cmd),
        .arm_to_fpga_cmd_valid  (arm_to_fpga_cmd_valid),
        .fpga_to_arm_done       (fpga_to_arm_done),
        .fpga_to_arm_done_read  (fpga_to_arm_done_read),
        .arm_to_fpga_data_valid (arm_to_fpga_data_valid),
        .arm_to_fpga_data_ready (arm_to_fpga_data_ready),
        .arm_to_fpga_data       (arm_to_fpga_data),
        .fpga_to_arm_data_valid (fpga_to_arm_data_valid),
        .fpga_to_arm_data_ready (fpga_to_arm_data_ready),
        .fpga_to_arm_data       (fpga_to_arm_data),
        .mod_q                  (mod_q),
        .rsq_q                  (rsq_q),
        .exp_q                  (exp_q),
        .exp_start              (exp_start),
        .mont_start             (mont_start),
        .core_done              (core_done),
        .core_result            (core_result),
        .leds                   (leds)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [511:0] LOAD_W = {32'ha1223da6, {14{32'h0f1e2d3c}}, 32'h7b6a9c4d};
    localparam logic [511:0] MONT_W = {32'h5764fd96, {14{32'h3c5a7e91}}, 32'h8842cdec};
    localparam logic [511:0] EXPR_W = {32'hbdb2a4a4, {14{32'h6d1c0b2e}}, 32'h55370189};
    localparam logic [511:0] A_W    = {16{32'h13579bdf}};
    localparam logic [511:0] B_W    = {16{32'h2468ace0}};

    int n_vec;
    int n_err;
    logic [DATA_W-1:0] sb_q[$];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [2:0] op);
        arm_to_fpga_cmd       = $urandom();
        arm_to_fpga_cmd[2:0]  = op;
        arm_to_fpga_cmd_valid = 1'b1;
        step();
        arm_to_fpga_cmd_valid = 1'b0;
        arm_to_fpga_cmd       = '0;
    endtask

    task automatic ack_done();
        for (int i = 0; i < 200 && fpga_to_arm_done !== 1'b1; i++) step();
        n_vec++;
        if (fpga_to_arm_done !== 1'b1) begin
            n_err++;
            $display("FAIL done_wait: done=%b, required 1 within 200 cycles", fpga_to_arm_done);
        end
        fpga_to_arm_done_read = 1'b1;
        step();
        fpga_to_arm_done_read = 1'b0;
        n_vec++;
        if (fpga_to_arm_done !== 1'b0 || leds[2:0] !== 3'd0) begin
            n_err++;
            $display("FAIL done_ack: done=%b state=%0d, required done=0 state=0",
                     fpga_to_arm_done, leds[2:0]);
        end
    endtask

    task automatic load_word(input logic [2:0] op, input logic [DATA_W-1:0] d);
        send_cmd(op);
        n_vec++;
        if (arm_to_fpga_data_ready !== 1'b1 || leds[2:0] !== 3'd1) begin
            n_err++;
            $display("FAIL rx_ready: ready=%b state=%0d, required ready=1 state=1",
                     arm_to_fpga_data_ready, leds[2:0]);
        end
        arm_to_fpga_data       = d;
        arm_to_fpga_data_valid = 1'b1;
        step();
        arm_to_fpga_data_valid = 1'b0;
        arm_to_fpga_data       = '1;
        n_vec++;
        if (arm_to_fpga_data_ready !== 1'b0 || fpga_to_arm_done !== 1'b1) begin
            n_err++;
            $display("FAIL rx_done: ready=%b done=%b, required ready=0 done=1",
                     arm_to_fpga_data_ready, fpga_to_arm_done);
        end
        ack_done();
    endtask

    // Start a core and model it answering after 'lat' cycles with 'res'.
    task automatic run_core(input logic [2:0] op, input logic [DATA_W-1:0] res, input int lat);
        send_cmd(op);
        n_vec++;
        if (exp_start !== (op == 3'd0) || mont_start !== (op == 3'd1)) begin
            n_err++;
            $display("FAIL start_pulse: exp_start=%b mont_start=%b for op %0d",
                     exp_start, mont_start, op);
        end
        step();
        n_vec++;
        if (exp_start !== 1'b0 || mont_start !== 1'b0 || leds[2:0] !== 3'd2) begin
            n_err++;
            $display("FAIL start_width: exp_start=%b mont_start=%b state=%0d, required 0 0 2",
                     exp_start, mont_start, leds[2:0]);
        end
        repeat (lat - 2) step();
        core_result = res;
        core_done   = 1'b1;
        step();
        core_done   = 1'b0;
        core_result = {32{32'hdeadbeef}};
        n_vec++;
        if (fpga_to_arm_done !== 1'b1 || fpga_to_arm_data !== res) begin
            n_err++;
            $display("FAIL core_latch: done=%b data=%h, required done=1 data=%h",
                     fpga_to_arm_done, fpga_to_arm_data[511:0], res[511:0]);
        end
    endtask

    // Issue WRITE, keep the ARM side not ready for 'hold' cycles, then pop and compare.
    task automatic recv_result(input int hold);
        logic [DATA_W-1:0] first;
        logic [DATA_W-1:0] want;
        fpga_to_arm_data_ready = 1'b0;
        send_cmd(3'd5);
        first = fpga_to_arm_data;
        n_vec++;
        if (fpga_to_arm_data_valid !== 1'b1) begin
            n_err++;
            $display("FAIL tx_valid: valid=%b, required 1", fpga_to_arm_data_valid);
        end
        for (int i = 0; i < hold; i++) begin
            step();
            n_vec++;
            if (fpga_to_arm_data_valid !== 1'b1 || fpga_to_arm_data !== first ||
                fpga_to_arm_done !== 1'b0) begin
                n_err++;
                $display("FAIL tx_hold cycle %0d: valid=%b done=%b stable=%b, required 1 0 1",
                         i, fpga_to_arm_data_valid, fpga_to_arm_done, fpga_to_arm_data === first);
            end
        end
        fpga_to_arm_data_ready = 1'b1;
        step();
        fpga_to_arm_data_ready = 1'b0;
        n_vec++;
        if (fpga_to_arm_data_valid !== 1'b0 || fpga_to_arm_done !== 1'b1) begin
            n_err++;
            $display("FAIL tx_handshake: valid=%b done=%b, required valid=0 done=1",
                     fpga_to_arm_data_valid, fpga_to_arm_done);
        end
        n_vec++;
        if (sb_q.size() == 0) begin
            n_err++;
            $display("FAIL tx_scoreboard: got %h with no expected word queued", first[511:0]);
        end else begin
            want = sb_q.pop_front();
            if (first !== want) begin
                n_err++;
                $display("FAIL tx_data: got %h, required %h", first[511:0], want[511:0]);
            end
        end
        ack_done();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) step();
        reset = 1'b0;
        n_vec++;
        if ({fpga_to_arm_done, arm_to_fpga_data_ready, fpga_to_arm_data_valid,
             exp_start, mont_start, leds} !== 9'd0) begin
            n_err++;
            $display("FAIL reset_ctrl: done=%b rdy=%b vld=%b es=%b ms=%b leds=%h, required all 0",
                     fpga_to_arm_done, arm_to_fpga_data_ready, fpga_to_arm_data_valid,
                     exp_start, mont_start, leds);
        end
        n_vec++;
        if (mod_q !== '0 || rsq_q !== '0 || exp_q !== '0 || fpga_to_arm_data !== '0) begin
            n_err++;
            $display("FAIL reset_data: mod=%h rsq=%h exp=%h res=%h, required 0",
                     mod_q[31:0], rsq_q[31:0], exp_q[31:0], fpga_to_arm_data[31:0]);
        end
    endtask

    task automatic test_load();
        load_word(3'd2, {512'd0, LOAD_W});
        n_vec++;
        if (mod_q !== {512'd0, LOAD_W} || rsq_q !== '0 || exp_q !== '0) begin
            n_err++;
            $display("FAIL load_mod: mod=%h rsq0=%b exp0=%b, required mod=%h others 0",
                     mod_q[511:0], rsq_q === '0, exp_q === '0, LOAD_W);
        end
    endtask

    task automatic test_montgomery();
        load_word(3'd3, {A_W, B_W});
        n_vec++;
        if (rsq_q !== {A_W, B_W}) begin
            n_err++;
            $display("FAIL load_rsq: got %h, required %h", rsq_q[511:0], B_W);
        end
        run_core(3'd1, {512'd0, MONT_W}, 20);
        sb_q.push_back({512'd0, MONT_W});
        ack_done();
        recv_result(3);
    endtask

    task automatic test_exponentiation();
        load_word(3'd2, {A_W, LOAD_W});
        load_word(3'd4, {1016'd0, 8'haf});
        load_word(3'd3, {B_W, A_W});
        n_vec++;
        if (exp_q !== {1016'd0, 8'haf} || mod_q !== {A_W, LOAD_W}) begin
            n_err++;
            $display("FAIL load_exp: exp=%h mod_ok=%b, required exp=af mod_ok=1",
                     exp_q[31:0], mod_q === {A_W, LOAD_W});
        end
        run_core(3'd0, {512'd0, EXPR_W}, 12);
        sb_q.push_back({512'd0, EXPR_W});
        ack_done();
        recv_result(0);
        sb_q.push_back({512'd0, EXPR_W});
        recv_result(2);
    endtask

    task automatic test_backpressure();
        sb_q.push_back({512'd0, EXPR_W});
        recv_result(50);
    endtask

    task automatic test_abuse();
        logic [DATA_W-1:0] mod_before;
        mod_before = mod_q;
        send_cmd(3'd0);
        repeat (3) step();
        send_cmd(3'd2);
        n_vec++;
        if (leds[2:0] !== 3'd2 || arm_to_fpga_data_ready !== 1'b0) begin
            n_err++;
            $display("FAIL cmd_in_run: state=%0d ready=%b, required state=2 ready=0",
                     leds[2:0], arm_to_fpga_data_ready);
        end
        core_result = {2{MONT_W}};
        core_done   = 1'b1;
        step();
        core_done   = 1'b0;
        ack_done();
        arm_to_fpga_data       = {2{EXPR_W}};
        arm_to_fpga_data_valid = 1'b1;
        step();
        arm_to_fpga_data_valid = 1'b0;
        send_cmd(3'd7);
        n_vec++;
        if (fpga_to_arm_done !== 1'b1 || mod_q !== mod_before ||
            fpga_to_arm_data !== {2{MONT_W}}) begin
            n_err++;
            $display("FAIL op7_noop: done=%b mod_same=%b res_ok=%b, required 1 1 1",
                     fpga_to_arm_done, mod_q === mod_before, fpga_to_arm_data === {2{MONT_W}});
        end
        ack_done();
        n_vec++;
`ifdef RSA_RESP_ERR_EN
        if (leds[3] !== 1'b1) begin
            n_err++;
            $display("FAIL err_set: leds[3]=%b, required 1", leds[3]);
        end
`else
        if (leds[3] !== 1'b0) begin
            n_err++;
            $display("FAIL err_absent: leds[3]=%b, required 0", leds[3]);
        end
`endif
        send_cmd(3'd3);
        reset = 1'b1;
        step();
        reset = 1'b0;
        n_vec++;
        if (leds !== 4'd0 || arm_to_fpga_data_ready !== 1'b0 || mod_q !== '0 ||
            rsq_q !== '0 || exp_q !== '0 || fpga_to_arm_data !== '0) begin
            n_err++;
            $display("FAIL reset_in_rx: leds=%h ready=%b regs_zero=%b, required 0 0 1",
                     leds, arm_to_fpga_data_ready,
                     (mod_q === '0) && (rsq_q === '0) && (exp_q === '0) && (fpga_to_arm_data === '0));
        end
        core_result = {2{LOAD_W}};
        core_done   = 1'b1;
        step();
        core_done   = 1'b0;
        n_vec++;
        if (fpga_to_arm_data !== '0 || leds !== 4'd0) begin
            n_err++;
            $display("FAIL stale_core_done: res=%h leds=%h, required 0 0",
                     fpga_to_arm_data[31:0], leds);
        end
    endtask

    task automatic test_done_timing();
        fpga_to_arm_done_read = 1'b1;
        send_cmd(3'd7);
        n_vec++;
        if (fpga_to_arm_done !== 1'b1) begin
            n_err++;
            $display("FAIL done_min_high: done=%b, required 1", fpga_to_arm_done);
        end
        step();
        fpga_to_arm_done_read = 1'b0;
        n_vec++;
        if (fpga_to_arm_done !== 1'b0 || leds[2:0] !== 3'd0) begin
            n_err++;
            $display("FAIL done_min_low: done=%b state=%0d, required 0 0",
                     fpga_to_arm_done, leds[2:0]);
        end
        send_cmd(3'd6);
        for (int i = 0; i < 100; i++) begin
            n_vec++;
            if (fpga_to_arm_done !== 1'b1) begin
                n_err++;
                $display("FAIL done_hold cycle %0d: done=%b, required 1", i, fpga_to_arm_done);
            end
            step();
        end
        ack_done();
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        reset                  = 1'b1;
        arm_to_fpga_cmd        = '0;
        arm_to_fpga_cmd_valid  = 1'b0;
        fpga_to_arm_done_read  = 1'b0;
        arm_to_fpga_data_valid = 1'b0;
        arm_to_fpga_data       = '0;
        fpga_to_arm_data_ready = 1'b0;
        core_done              = 1'b0;
        core_result            = '0;
        test_reset();
        test_load();
        test_montgomery();
        test_exponentiation();
        test_backpressure();
        test_abuse();
        test_done_timing();
        n_vec++;
        if (sb_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: %0d words left, required 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
